servo_angle_ramp: RTL and testbench

Slew-rate limiter that sits directly upstream of the servo PWM generator. It accepts target angles (0–180°) over a valid/ready handshake and drives a registered 8-bit commanded angle into the PWM stage. Once per servo frame (50 Hz), the commanded angle moves toward the target by at most STEP_DEG degrees. This prevents abrupt servo jumps and current spikes when the arm is retargeted.

---
 rtl/servo_angle_ramp_if.sv | 9 +
 rtl/servo_angle_ramp.sv | 97 +++++++++
 tb/tb_servo_angle_ramp.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/servo_angle_ramp_if.sv
// Target-angle handshake between a command source (master) and the servo ramp (slave).
interface servo_angle_ramp_if;
  logic       target_valid;
  logic [7:0] target_angle;
  logic       target_ready;

  modport master (output target_valid, output target_angle, input target_ready);
  modport slave  (input target_valid, input target_angle, output target_ready);
endinterface

// File: rtl/servo_angle_ramp.sv
// Servo slew-rate limiter: walks the commanded angle toward the latched target by at most
// STEP_DEG degrees once per frame tick.
//   state    | meaning
//   S_IDLE   | angle equals latched target, nothing to do
//   S_MOVING | angle differs from target, steps on each enabled tick
module servo_angle_ramp #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int UPDATE_HZ   = 50,
  parameter int STEP_DEG    = 2,
  parameter int MAX_ANGLE   = 180,
  parameter int RESET_ANGLE = 90
) (
  input  logic                clk,
  input  logic                reset_n,
  servo_angle_ramp_if.slave   tgt_if,
  input  logic                enable_i,
  output logic [7:0]          angle_o,
  output logic                moving_o,
  output logic                at_target_o,
  output logic                update_tick_o
);

  localparam int TICK_CYCLES = CLK_HZ / UPDATE_HZ;
  localparam int CNT_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [7:0] MAX_A  = 8'(MAX_ANGLE);
  localparam logic [7:0] RST_A  = 8'(RESET_ANGLE);
  localparam logic [7:0] STEP_A = 8'(STEP_DEG);

  typedef enum logic {S_IDLE, S_MOVING} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         angle_q, angle_d;
  logic [7:0]         target_q, target_d;
  logic               at_target_q, at_target_d;
  logic               tick_q;
  logic               ready_q;
  logic               tick;
  logic               xfer;
  logic [7:0]         target_clamped;
  logic signed [8:0]  diff;
  logic [8:0]         mag;

  assign tick    = (count_q == CNT_LAST);
  assign count_d = tick ? '0 : count_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      angle_q     <= RST_A;
      target_q    <= RST_A;
      at_target_q <= 1'b1;
      tick_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      angle_q     <= angle_d;
      target_q    <= target_d;
      at_target_q <= at_target_d;
      tick_q      <= tick;
      ready_q     <= 1'b1;
    end
  end

  // The step always uses the old target; a same-edge transfer only affects the next state.
  always_comb begin
    target_clamped = (tgt_if.target_angle > MAX_A) ? MAX_A : tgt_if.target_angle;
    xfer           = tgt_if.target_valid && ready_q;
    diff           = $signed({1'b0, target_q}) - $signed({1'b0, angle_q});
    mag            = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    angle_d        = angle_q;
    target_d       = xfer ? target_clamped : target_q;

    if ((state_q == S_MOVING) && tick && enable_i) begin
      if (mag <= {1'b0, STEP_A}) begin
        angle_d = target_q;
      end else if (diff[8]) begin
        angle_d = angle_q - STEP_A;
      end else begin
        angle_d = angle_q + STEP_A;
      end
    end

    state_d     = (angle_d != target_d) ? S_MOVING : S_IDLE;
    at_target_d = (angle_d == target_d);
  end

  assign tgt_if.target_ready = ready_q;
  assign angle_o             = angle_q;
  assign moving_o            = (state_q == S_MOVING);
  assign at_target_o         = at_target_q;
  assign update_tick_o       = tick_q;

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp with a 10-cycle tick; a second instance uses a 7-degree step.
module tb_servo_angle_ramp;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       enable7;
  logic [7:0] angle, angle7;
  logic       moving, moving7;
  logic       at_target, at_target7;
  logic       update_tick, update_tick7;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         c;

  always #5 clk = ~clk;

  servo_angle_ramp_if ifm ();
  servo_angle_ramp_if if7 ();

  servo_angle_ramp #(
    .CLK_HZ(500), .UPDATE_HZ(50), .STEP_DEG(2), .MAX_ANGLE(180), .RESET_ANGLE(90)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tgt_if(ifm), .enable_i(enable),
    .angle_o(angle), .moving_o(moving), .at_target_o(at_target), .update_tick_o(update_tick)
  );

  servo_angle_ramp #(
    .CLK_HZ(500), .UPDATE_HZ(50), .STEP_DEG(7), .MAX_ANGLE(180), .RESET_ANGLE(90)
  ) dut7 (
    .clk(clk), .reset_n(reset_n), .tgt_if(if7), .enable_i(enable7),
    .angle_o(angle7), .moving_o(moving7), .at_target_o(at_target7), .update_tick_o(update_tick7)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic next_tick(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (update_tick === 1'b1) begin
        cyc = i;
        break;
      end
    end
    check("tick_wait", update_tick, 1);
  endtask

  task automatic send(input logic [7:0] a);
    ifm.target_valid = 1'b1;
    ifm.target_angle = a;
    @(negedge clk);
    ifm.target_valid = 1'b0;
  endtask

  task automatic send7(input logic [7:0] a);
    if7.target_valid = 1'b1;
    if7.target_angle = a;
    @(negedge clk);
    if7.target_valid = 1'b0;
  endtask

  initial begin
    reset_n          = 1'b1;
    enable           = 1'b1;
    enable7          = 1'b1;
    ifm.target_valid = 1'b0;
    ifm.target_angle = 8'd0;
    if7.target_valid = 1'b0;
    if7.target_angle = 8'd0;
    #1 reset_n = 1'b0;

    // 1: reset values, ready after first edge, tick period
    #11;
    check("rst_angle", angle, 90);
    check("rst_moving", moving, 0);
    check("rst_at_target", at_target, 1);
    check("rst_tick", update_tick, 0);
    check("rst_ready", ifm.target_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_edge", ifm.target_ready, 1);
    next_tick(c);
    check("first_tick_gap", c, 9);
    next_tick(c);
    check("tick_period", c, 10);
    check("idle_angle", angle, 90);

    // 2: ramp to 100
    send(8'd100);
    check("tick_one_cycle", update_tick, 0);
    check("t2_moving", moving, 1);
    check("t2_at_target", at_target, 0);
    for (int k = 1; k <= 5; k++) begin
      next_tick(c);
      check("t2_angle", angle, 9'(90 + 2 * k));
      if (k < 5) check("t2_moving_mid", moving, 1);
    end
    check("t2_moving_end", moving, 0);
    check("t2_at_target_end", at_target, 1);

    // 3: clamp at 180
    send(8'd250);
    check("t3_moving", moving, 1);
    for (int k = 1; k <= 40; k++) begin
      next_tick(c);
      check("t3_angle", angle, 9'(100 + 2 * k));
    end
    check("t3_moving_end", moving, 0);
    check("t3_at_target_end", at_target, 1);
    for (int k = 0; k < 2; k++) begin
      next_tick(c);
      check("t3_hold_180", angle, 180);
    end

    // 3b: step 7, up to 180 then down to 0 without wrapping
    send7(8'd180);
    check("t3b_moving", moving7, 1);
    for (int k = 1; k <= 13; k++) begin
      next_tick(c);
      check("t3b_tick7", update_tick7, 1);
      check("t3b_up", angle7, (k < 13) ? 9'(90 + 7 * k) : 9'd180);
    end
    check("t3b_up_done", moving7, 0);
    send7(8'd0);
    for (int k = 1; k <= 26; k++) begin
      next_tick(c);
      check("t3b_down", angle7, (k < 26) ? 9'(180 - 7 * k) : 9'd0);
    end
    check("t3b_down_done", at_target7, 1);
    next_tick(c);
    check("t3b_hold_0", angle7, 0);

    // 4: back to 90, then toward 120 with an enable freeze
    send(8'd90);
    for (int k = 1; k <= 45; k++) begin
      next_tick(c);
      check("t4_down", angle, 9'(180 - 2 * k));
    end
    send(8'd120);
    for (int k = 1; k <= 3; k++) begin
      next_tick(c);
      check("t4_up", angle, 9'(90 + 2 * k));
    end
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      next_tick(c);
      check("t4_frozen_gap", c, 10);
      check("t4_frozen_angle", angle, 96);
      check("t4_frozen_moving", moving, 1);
    end
    enable = 1'b1;
    next_tick(c);
    check("t4_resume", angle, 98);

    // 5: retarget to 80 in the tick cycle; the step still uses target 120
    repeat (9) @(negedge clk);
    ifm.target_valid = 1'b1;
    ifm.target_angle = 8'd80;
    @(negedge clk);
    ifm.target_valid = 1'b0;
    check("t5_tick", update_tick, 1);
    check("t5_old_target_step", angle, 100);
    check("t5_moving", moving, 1);
    for (int k = 1; k <= 10; k++) begin
      next_tick(c);
      check("t5_down", angle, 9'(100 - 2 * k));
    end
    check("t5_moving_end", moving, 0);
    check("t5_at_target_end", at_target, 1);
    send(8'd80);
    check("t5_equal_moving", moving, 0);
    check("t5_equal_at_target", at_target, 1);
    check("t5_equal_angle", angle, 80);

    // 6: async reset mid-move at 110
    send(8'd120);
    check("t6_moving", moving, 1);
    for (int k = 1; k <= 15; k++) begin
      next_tick(c);
      check("t6_up", angle, 9'(80 + 2 * k));
    end
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_angle", angle, 90);
    check("t6_rst_moving", moving, 0);
    check("t6_rst_at_target", at_target, 1);
    check("t6_rst_tick", update_tick, 0);
    check("t6_rst_ready", ifm.target_ready, 0);
    check("t6_rst_angle7", angle7, 90);
    @(negedge clk);
    reset_n = 1'b1;
    next_tick(c);
    check("t6_first_tick_gap", c, 10);
    check("t6_angle_after", angle, 90);
    check("t6_moving_after", moving, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
